vga_timing_gen: RTL and testbench
=================================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL declare parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL declare parameter H_FP/H_SYNC/H_BP, defaults 16/96/48; H_TOTAL = 800.
REQ-003 SHALL declare parameter V_ACTIVE, default 480, visible lines per frame.
REQ-004 SHALL declare parameter V_FP/V_SYNC/V_BP, defaults 10/2/33; V_TOTAL = 525.
REQ-005 SHALL declare parameter PIPE_DELAY, default 1, pixel ticks of draw-logic latency to compensate; legal 1..4.
REQ-006 SHALL have one clock and a synchronous, active-high reset: ports clk (in, 1, 50 MHz system clock) and reset (in, 1, sync active-high).
REQ-007 SHALL have RGB_in (in, 8): RGB332 pixel colour from the object mux, valid for the pixel at the current pixelX/pixelY delayed by PIPE_DELAY ticks.
REQ-008 SHALL have pixelX and pixelY (out, 11 each): current raster coordinates fed to all draw blocks.
REQ-009 SHALL have pixelTick (out, 1): one-clk strobe marking the clk edge on which the counters advance.
REQ-010 SHALL have startOfFrame (out, 1): one-clk pulse when the counters enter (0,0).
REQ-011 SHALL have hsyncN and vsyncN (out, 1 each, active-low), blankN (out, 1, high = visible), and vga_R/vga_G/vga_B (out, 8 each).
REQ-012 SHALL have frameCount (out, 16): number of completed frames.

Function
REQ-013 pixelTick SHALL be high on every second clk cycle (25 MHz); the first high is on the 2nd cycle after reset deasserts.
REQ-014 On each clk edge with pixelTick high, pixelX SHALL increment; 799 SHALL wrap to 0 and increment pixelY.
REQ-015 pixelY SHALL wrap from 524 to 0; pixelX/pixelY SHALL hold between ticks.
REQ-016 Raw hsync SHALL be low for pixelX 656..751 inclusive; raw vsync SHALL be low for pixelY 490..491; raw active SHALL be pixelX<640 && pixelY<480.
REQ-017 hsyncN, vsyncN and blankN SHALL equal the raw signals delayed by exactly PIPE_DELAY+1 pixel ticks, via a shift register that advances only on pixelTick.
REQ-018 RGB_in SHALL be captured on pixelTick into a 1-tick output register aligned with the delayed blankN.
REQ-019 Expansion SHALL be R8={r,r,r[2:1]}, G8={g,g,g[2:1]}, B8={b,b,b,b} by bit replication (RGB332 0xFF -> FF/FF/FF; 0xE0 -> FF/00/00).
REQ-020 vga_R/G/B SHALL be 0 whenever delayed blankN is 0, regardless of RGB_in.
REQ-021 startOfFrame SHALL be high for exactly one clk: the edge at which the counters move from (799,524) to (0,0).
REQ-022 frameCount SHALL increment on that same edge and wrap from 0xFFFF to 0.
REQ-023 The module SHALL contain no combinational path from RGB_in to any output.

Reset
REQ-024 While reset is high, pixelX, pixelY, frameCount, RGB outputs, startOfFrame and pixelTick SHALL be 0; hsyncN and vsyncN SHALL be 1; blankN SHALL be 0; all delay stages SHALL be cleared to the inactive values.
REQ-025 Reset asserted mid-frame SHALL take effect on the next clk edge, with no partial-line completion; no startOfFrame pulse SHALL occur on reset release.

Structure
REQ-026 Package vga_pkg SHALL hold the default timing constants, the rgb332_t packed typedef (r[2:0], g[2:0], b[1:0]) and the expansion function.
REQ-027 Sub-module vga_sync_delay (parameterised depth, tick-enabled 3-bit shift register for hsync/vsync/active) SHALL be used for REQ-017.

Verification
REQ-028 Release reset, count clks -> first pixelTick on cycle 2; pixelX=1 after the first tick; 1600 clks per line, 840000 clks per frame.
REQ-029 Run one frame with PIPE_DELAY=1 -> hsyncN low for exactly 96 ticks starting 2 ticks after pixelX=656; vsyncN low for exactly 2 lines.
REQ-030 Drive RGB_in=0xFF constantly -> vga_R/G/B=0xFF only while blankN=1 (640x480 visible ticks per frame), and 0 in blanking.
REQ-031 Drive RGB_in=0xE0 then 0x03 -> outputs FF/00/00 then 00/00/FF.
REQ-032 Run three frames -> exactly three single-clk startOfFrame pulses; frameCount=3; preload frameCount to 0xFFFF via force -> wraps to 0.
REQ-033 Assert reset at pixel (300,200) for 1 clk -> next cycle all outputs equal reset values; the counters restart from (0,0) with no startOfFrame pulse.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, RGB332 pixel type and colour expansion helper.
package vga_pkg;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned H_FP_DEF     = 16;
  localparam int unsigned H_SYNC_DEF   = 96;
  localparam int unsigned H_BP_DEF     = 48;
  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned V_FP_DEF     = 10;
  localparam int unsigned V_SYNC_DEF   = 2;
  localparam int unsigned V_BP_DEF     = 33;

  localparam int unsigned COORD_W = 11;

  // Delay-line word is {hsync_n, vsync_n, active}; idle means syncs high, blanked.
  localparam logic [2:0] SYNC_IDLE = 3'b110;

  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
  } rgb332_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  function automatic rgb888_t expand_rgb332(input rgb332_t c);
    rgb888_t o;
    o.r = {c.r, c.r, c.r[2:1]};
    o.g = {c.g, c.g, c.g[2:1]};
    o.b = {c.b, c.b, c.b, c.b};
    return o;
  endfunction

endpackage

// File: rtl/vga_timing_gen_sync_delay.sv
// Tick-enabled shift register carrying hsync/vsync/active down the pixel pipeline.
module vga_sync_delay import vga_pkg::*; #(
  parameter int unsigned DEPTH = 2
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_tick,
  input  logic [2:0] i_sync,
  output logic [2:0] o_sync
);

  logic [2:0] r_stage [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < int'(DEPTH); i++) r_stage[i] <= SYNC_IDLE;
    end else if (i_tick) begin
      r_stage[0] <= i_sync;
      for (int i = 1; i < int'(DEPTH); i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_sync = r_stage[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: 25 MHz pixel strobe from a 50 MHz clock, counters, sync and
// blank aligned to a draw pipeline of PIPE_DELAY ticks, RGB332 to 24-bit output.
module vga_timing_gen import vga_pkg::*; #(
  parameter int unsigned H_ACTIVE   = H_ACTIVE_DEF,
  parameter int unsigned H_FP       = H_FP_DEF,
  parameter int unsigned H_SYNC     = H_SYNC_DEF,
  parameter int unsigned H_BP       = H_BP_DEF,
  parameter int unsigned V_ACTIVE   = V_ACTIVE_DEF,
  parameter int unsigned V_FP       = V_FP_DEF,
  parameter int unsigned V_SYNC     = V_SYNC_DEF,
  parameter int unsigned V_BP       = V_BP_DEF,
  parameter int unsigned PIPE_DELAY = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         RGB_in,
  output logic [COORD_W-1:0] pixelX,
  output logic [COORD_W-1:0] pixelY,
  output logic               pixelTick,
  output logic               startOfFrame,
  output logic               hsyncN,
  output logic               vsyncN,
  output logic               blankN,
  output logic [7:0]         vga_R,
  output logic [7:0]         vga_G,
  output logic [7:0]         vga_B,
  output logic [15:0]        frameCount
);

  localparam logic [COORD_W-1:0] H_LAST     = COORD_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [COORD_W-1:0] V_LAST     = COORD_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [COORD_W-1:0] H_VIS      = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] V_VIS      = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W-1:0] H_SYNC_BEG = COORD_W'(H_ACTIVE + H_FP);
  localparam logic [COORD_W-1:0] H_SYNC_END = COORD_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [COORD_W-1:0] V_SYNC_BEG = COORD_W'(V_ACTIVE + V_FP);
  localparam logic [COORD_W-1:0] V_SYNC_END = COORD_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic               r_tick;
  logic               r_sof;
  logic [COORD_W-1:0] r_x;
  logic [COORD_W-1:0] r_y;
  logic [15:0]        r_frame_cnt;
  rgb332_t            r_rgb;

  logic       w_end_line;
  logic       w_end_frame;
  logic       w_hsync_n;
  logic       w_vsync_n;
  logic       w_active;
  logic [2:0] w_sync_dly;
  rgb888_t    w_rgb888;

  assign w_end_line  = (r_x == H_LAST);
  assign w_end_frame = w_end_line && (r_y == V_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tick      <= 1'b0;
      r_sof       <= 1'b0;
      r_x         <= '0;
      r_y         <= '0;
      r_frame_cnt <= '0;
      r_rgb       <= '0;
    end else begin
      r_tick <= ~r_tick;
      r_sof  <= r_tick && w_end_frame;
      if (r_tick) begin
        r_rgb <= rgb332_t'(RGB_in);
        if (w_end_line) begin
          r_x <= '0;
          r_y <= (r_y == V_LAST) ? '0 : r_y + COORD_W'(1);
        end else begin
          r_x <= r_x + COORD_W'(1);
        end
        if (w_end_frame) r_frame_cnt <= r_frame_cnt + 16'd1;
      end
    end
  end

  assign w_hsync_n = !((r_x >= H_SYNC_BEG) && (r_x <= H_SYNC_END));
  assign w_vsync_n = !((r_y >= V_SYNC_BEG) && (r_y <= V_SYNC_END));
  assign w_active  = (r_x < H_VIS) && (r_y < V_VIS);

  // One extra stage beyond the draw latency matches the registered RGB capture.
  vga_sync_delay #(
    .DEPTH (PIPE_DELAY + 1)
  ) u_sync_delay (
    .i_clk   (clk),
    .i_reset (reset),
    .i_tick  (r_tick),
    .i_sync  ({w_hsync_n, w_vsync_n, w_active}),
    .o_sync  (w_sync_dly)
  );

  assign hsyncN = w_sync_dly[2];
  assign vsyncN = w_sync_dly[1];
  assign blankN = w_sync_dly[0];

  assign w_rgb888 = expand_rgb332(r_rgb);
  assign vga_R    = blankN ? w_rgb888.r : 8'h00;
  assign vga_G    = blankN ? w_rgb888.g : 8'h00;
  assign vga_B    = blankN ? w_rgb888.b : 8'h00;

  assign pixelX       = r_x;
  assign pixelY       = r_y;
  assign pixelTick    = r_tick;
  assign startOfFrame = r_sof;
  assign frameCount   = r_frame_cnt;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default-timing instance for line-level checks, a shrunken
// raster (16x8 total, 8x4 visible) for frame-level checks.
module tb_vga_timing_gen;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] rgb_in = 8'h00;

  logic [10:0] d_x, d_y;
  logic        d_tick, d_sof, d_hs, d_vs, d_blank;
  logic [7:0]  d_r, d_g, d_b;
  logic [15:0] d_fc;

  logic [10:0] s_x, s_y;
  logic        s_tick, s_sof, s_hs, s_vs, s_blank;
  logic [7:0]  s_r, s_g, s_b;
  logic [15:0] s_fc;

  int n_vec = 0;
  int n_err = 0;

  always #10 clk = ~clk;

  vga_timing_gen dut_d (
    .clk          (clk),
    .reset        (reset),
    .RGB_in       (rgb_in),
    .pixelX       (d_x),
    .pixelY       (d_y),
    .pixelTick    (d_tick),
    .startOfFrame (d_sof),
    .hsyncN       (d_hs),
    .vsyncN       (d_vs),
    .blankN       (d_blank),
    .vga_R        (d_r),
    .vga_G        (d_g),
    .vga_B        (d_b),
    .frameCount   (d_fc)
  );

  // Sync x=10..12, vsync y=5..6, 128 ticks (256 clks) per frame.
  vga_timing_gen #(
    .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (3),
    .V_ACTIVE (4), .V_FP (1), .V_SYNC (2), .V_BP (1),
    .PIPE_DELAY (1)
  ) dut_s (
    .clk          (clk),
    .reset        (reset),
    .RGB_in       (rgb_in),
    .pixelX       (s_x),
    .pixelY       (s_y),
    .pixelTick    (s_tick),
    .startOfFrame (s_sof),
    .hsyncN       (s_hs),
    .vsyncN       (s_vs),
    .blankN       (s_blank),
    .vga_R        (s_r),
    .vga_G        (s_g),
    .vga_B        (s_b),
    .frameCount   (s_fc)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_small_reset(input string tag);
    check_eq({tag, "_xy"}, {s_x, s_y}, 32'h0);
    check_eq({tag, "_ctl"}, {s_tick, s_sof, s_hs, s_vs, s_blank}, 32'b00110);
    check_eq({tag, "_rgb"}, {s_r, s_g, s_b}, 32'h0);
    check_eq({tag, "_fc"}, s_fc, 32'h0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, hs_low, hs_first_x, sof_cnt, sof_first, blank_clks, vs_low, bad_rgb;

    repeat (3) step();
    check_eq("rst_d_xy", {d_x, d_y}, 32'h0);
    check_eq("rst_d_ctl", {d_tick, d_sof, d_hs, d_vs, d_blank}, 32'b00110);
    check_eq("rst_d_rgb", {d_r, d_g, d_b}, 32'h0);
    check_eq("rst_d_fc", d_fc, 32'h0);
    check_small_reset("rst_s");

    // Default timing: tick phase, first advance, line length, hsync placement.
    reset = 1'b0;
    check_eq("tick_cyc1", d_tick, 32'd0);
    step();
    check_eq("tick_cyc2", d_tick, 32'd1);
    check_eq("x_before_tick", d_x, 32'd0);
    step();
    check_eq("x_after_tick", d_x, 32'd1);
    n = 2; hs_low = 0; hs_first_x = -1;
    while (d_y != 11'd1 && n < 4000) begin
      step();
      n++;
      if (!d_hs) begin
        hs_low++;
        if (hs_first_x < 0) hs_first_x = int'(d_x);
      end
    end
    check_eq("clks_per_line", n, 32'd1600);
    check_eq("line_wrap_x", d_x, 32'd0);
    check_eq("hs_low_clks", hs_low, 32'd192);
    check_eq("hs_first_x", hs_first_x, 32'd658);

    // Small raster: three frames with white input.
    reset = 1'b1;
    rgb_in = 8'hFF;
    step();
    step();
    reset = 1'b0;
    sof_cnt = 0; sof_first = 0; blank_clks = 0; vs_low = 0; hs_low = 0; bad_rgb = 0;
    for (int i = 1; i <= 768; i++) begin
      step();
      if (s_sof) begin
        sof_cnt++;
        if (sof_first == 0) sof_first = i;
      end
      if (s_blank) blank_clks++;
      if (!s_vs) vs_low++;
      if (!s_hs) hs_low++;
      if ({s_r, s_g, s_b} !== (s_blank ? 24'hFFFFFF : 24'h000000)) bad_rgb++;
    end
    check_eq("sof_pulses", sof_cnt, 32'd3);
    check_eq("sof_first_clk", sof_first, 32'd256);
    check_eq("fc_after_3", s_fc, 32'd3);
    check_eq("xy_at_sof", {s_x, s_y}, 32'h0);
    check_eq("blank_hi_clks", blank_clks, 32'd192);
    check_eq("vs_low_clks", vs_low, 32'd192);
    check_eq("hs_low_clks_s", hs_low, 32'd144);
    check_eq("rgb_gating_bad", bad_rgb, 32'd0);

    // Colour expansion: 0xE0 then 0x03.
    rgb_in = 8'hE0;
    n = 0;
    while (!s_blank && n < 100) begin
      step();
      n++;
    end
    check_eq("blank_rise_seen", s_blank, 32'd1);
    check_eq("rgb_e0", {s_r, s_g, s_b}, 32'hFF0000);
    rgb_in = 8'h03;
    step();
    step();
    check_eq("blank_still_hi", s_blank, 32'd1);
    check_eq("rgb_03", {s_r, s_g, s_b}, 32'h0000FF);
    n = 0;
    while (s_blank && n < 100) begin
      step();
      n++;
    end
    check_eq("blank_fall_seen", s_blank, 32'd0);
    check_eq("rgb_blanked", {s_r, s_g, s_b}, 32'h0);

    // Mid-frame reset at (5,2).
    n = 0;
    while (!(s_x == 11'd5 && s_y == 11'd2) && n < 600) begin
      step();
      n++;
    end
    check_eq("reach_5_2", {s_x, s_y}, {11'd5, 11'd2});
    reset = 1'b1;
    step();
    check_small_reset("mid_rst");
    reset = 1'b0;
    sof_cnt = 0;
    for (int i = 0; i < 2; i++) begin
      step();
      if (s_sof) sof_cnt++;
    end
    check_eq("restart_xy", {s_x, s_y}, {11'd1, 11'd0});
    for (int i = 0; i < 18; i++) begin
      step();
      if (s_sof) sof_cnt++;
    end
    check_eq("no_sof_release", sof_cnt, 32'd0);

    // frameCount wrap from 0xFFFF.
    force dut_s.r_frame_cnt = 16'hFFFF;
    step();
    release dut_s.r_frame_cnt;
    step();
    check_eq("fc_preload", s_fc, 32'hFFFF);
    n = 0;
    while (!s_sof && n < 600) begin
      step();
      n++;
    end
    check_eq("wrap_sof_seen", s_sof, 32'd1);
    check_eq("fc_wrap", s_fc, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
